// File: rtl/bus_reg_slave.sv
// AZPR-style bus slave: decodes a strobe, inserts fixed wait states, then
// completes with a one-cycle active-low ready. Holds a word register file plus a read-only transaction counter.
module bus_reg_slave #(
  parameter int REG_ADDR_W  = 4,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs_,
  input  logic        as_,
  input  logic        rw,
  input  logic [29:0] addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        rdy_
);

  localparam int NUM_REGS = 2 ** REG_ADDR_W;
  localparam logic [REG_ADDR_W-1:0] CNT_IDX = '1;
  localparam logic ZERO_WAIT = (WAIT_CYCLES == 0);
  localparam logic [3:0] WAIT_LOAD = ZERO_WAIT ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t                  state_q,   state_d;
  logic [3:0]              wait_cnt_q, wait_cnt_d;
  logic [REG_ADDR_W-1:0]   idx_q,     idx_d;
  logic                    rw_q,      rw_d;
  logic [31:0]             wr_data_q, wr_data_d;
  logic [31:0]             rd_data_q, rd_data_d;
  logic                    rdy_q,     rdy_d;
  logic [31:0]             xact_cnt_q, xact_cnt_d;
  logic [31:0]             regs_q [NUM_REGS];
  logic [31:0]             regs_d [NUM_REGS];

  logic                    req;
  logic                    complete;
  logic [REG_ADDR_W-1:0]   acc_idx;
  logic                    acc_rw;
  logic [31:0]             acc_wr_data;
  logic                    unused_addr_bits;

  assign req              = !cs_ && !as_;
  assign unused_addr_bits = ^addr[29:REG_ADDR_W];

  // A zero-wait access completes on the accepting edge, so it must use the live inputs.
  assign acc_idx     = (state_q == S_IDLE) ? addr[REG_ADDR_W-1:0] : idx_q;
  assign acc_rw      = (state_q == S_IDLE) ? rw : rw_q;
  assign acc_wr_data = (state_q == S_IDLE) ? wr_data : wr_data_q;

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    idx_d      = idx_q;
    rw_d       = rw_q;
    wr_data_d  = wr_data_q;
    rd_data_d  = '0;
    rdy_d      = 1'b1;
    xact_cnt_d = xact_cnt_q;
    regs_d     = regs_q;
    complete   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req) begin
          idx_d     = addr[REG_ADDR_W-1:0];
          rw_d      = rw;
          wr_data_d = wr_data;
          if (ZERO_WAIT) begin
            complete = 1'b1;
          end else begin
            state_d    = S_WAIT;
            wait_cnt_d = WAIT_LOAD;
          end
        end
      end
      S_WAIT: begin
        if (!req) begin
          state_d = S_IDLE;
        end else if (wait_cnt_q == 4'd0) begin
          complete = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // The counter slot reads the pre-increment count and silently drops writes.
    if (complete) begin
      state_d    = S_RESP;
      rdy_d      = 1'b0;
      xact_cnt_d = xact_cnt_q + 32'd1;
      if (acc_rw) begin
        rd_data_d = (acc_idx == CNT_IDX) ? xact_cnt_q : regs_q[acc_idx];
      end else if (acc_idx != CNT_IDX) begin
        regs_d[acc_idx] = acc_wr_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= '0;
      idx_q      <= '0;
      rw_q       <= 1'b0;
      wr_data_q  <= '0;
      rd_data_q  <= '0;
      rdy_q      <= 1'b1;
      xact_cnt_q <= '0;
      regs_q     <= '{default: '0};
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      idx_q      <= idx_d;
      rw_q       <= rw_d;
      wr_data_q  <= wr_data_d;
      rd_data_q  <= rd_data_d;
      rdy_q      <= rdy_d;
      xact_cnt_q <= xact_cnt_d;
      regs_q     <= regs_d;
    end
  end

  assign rd_data = rd_data_q;
  assign rdy_    = rdy_q;

endmodule

// File: tb/tb_bus_reg_slave.sv
// Scoreboard bench for bus_reg_slave: one instance with two wait states and
// one with zero wait states, each checked by a negedge monitor against expected responses.
module tb_bus_reg_slave;

  typedef struct {
    int          cyc;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  int          cyc = 0;

  logic        cs_a = 1'b1, as_a = 1'b1, rw_a = 1'b1;
  logic [29:0] addr_a = '0;
  logic [31:0] wr_data_a = '0;
  logic [31:0] rd_data_a;
  logic        rdy_a;

  logic        cs_b = 1'b1, as_b = 1'b1, rw_b = 1'b1;
  logic [29:0] addr_b = '0;
  logic [31:0] wr_data_b = '0;
  logic [31:0] rd_data_b;
  logic        rdy_b;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;

  int n_compared = 0;
  int n_mismatched = 0;

  bus_reg_slave #(.REG_ADDR_W(4), .WAIT_CYCLES(2)) dut_a (
    .clk(clk), .reset(reset), .cs_(cs_a), .as_(as_a), .rw(rw_a),
    .addr(addr_a), .wr_data(wr_data_a), .rd_data(rd_data_a), .rdy_(rdy_a)
  );

  bus_reg_slave #(.REG_ADDR_W(4), .WAIT_CYCLES(0)) dut_b (
    .clk(clk), .reset(reset), .cs_(cs_b), .as_(as_b), .rw(rw_b),
    .addr(addr_b), .wr_data(wr_data_b), .rd_data(rd_data_b), .rdy_(rdy_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Monitor: every ready pulse must match the next queued response in both cycle and data.
  always @(negedge clk) begin
    if (rdy_a === 1'b0) begin
      if (qa.size() == 0) begin
        checkOutput("A.unexpected_rdy_", {31'b0, rdy_a}, 32'd1);
      end else begin
        ea = qa.pop_front();
        checkOutput("A.rdy_cycle", 32'(cyc), 32'(ea.cyc));
        checkOutput("A.rd_data", rd_data_a, ea.data);
      end
    end else begin
      checkOutput("A.idle_rd_data", rd_data_a, 32'd0);
    end

    if (rdy_b === 1'b0) begin
      if (qb.size() == 0) begin
        checkOutput("B.unexpected_rdy_", {31'b0, rdy_b}, 32'd1);
      end else begin
        eb = qb.pop_front();
        checkOutput("B.rdy_cycle", 32'(cyc), 32'(eb.cyc));
        checkOutput("B.rd_data", rd_data_b, eb.data);
      end
    end else begin
      checkOutput("B.idle_rd_data", rd_data_b, 32'd0);
    end
  end

  task automatic doReset();
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // One complete access on the two-wait-state slave; ready is due WAIT_CYCLES edges after acceptance.
  task automatic applyStimulus(input logic rw, input logic [29:0] addr, input logic [31:0] wdata,
                               input logic [31:0] exp_data);
    bit seen = 0;
    @(posedge clk);
    #1;
    cs_a = 1'b0; as_a = 1'b0; rw_a = rw; addr_a = addr; wr_data_a = wdata;
    qa.push_back('{cyc: cyc + 1 + 2, data: exp_data});
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (rdy_a === 1'b0) seen = 1;
    end
    if (!seen) checkOutput("A.rdy_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
    cs_a = 1'b1; as_a = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit seen;

    // Reset, then the first read of an untouched register.
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    applyStimulus(1'b1, 30'h3, 32'h0, 32'h0);

    // Write then read through an aliased address.
    applyStimulus(1'b0, 30'h5, 32'hDEADBEEF, 32'h0);
    applyStimulus(1'b1, 30'h15, 32'h0, 32'hDEADBEEF);

    // Abort in the first wait cycle: nothing written, nothing counted.
    doReset();
    @(posedge clk);
    #1;
    cs_a = 1'b0; as_a = 1'b0; rw_a = 1'b0; addr_a = 30'h2; wr_data_a = 32'h12345678;
    @(posedge clk);
    #1 as_a = 1'b1; cs_a = 1'b1;
    repeat (5) @(posedge clk);
    applyStimulus(1'b1, 30'h2, 32'h0, 32'h0);
    applyStimulus(1'b1, 30'hF, 32'h0, 32'd1);

    // Counter: five accesses, then the read-only slot, an ignored write to it, and a read again.
    doReset();
    applyStimulus(1'b0, 30'h0, 32'h11111111, 32'h0);
    applyStimulus(1'b0, 30'h1, 32'h22222222, 32'h0);
    applyStimulus(1'b1, 30'h0, 32'h0, 32'h11111111);
    applyStimulus(1'b1, 30'h1, 32'h0, 32'h22222222);
    applyStimulus(1'b0, 30'hE, 32'hA5A5A5A5, 32'h0);
    applyStimulus(1'b1, 30'hF, 32'h0, 32'd5);
    applyStimulus(1'b0, 30'hF, 32'h0000FFFF, 32'h0);
    applyStimulus(1'b1, 30'hF, 32'h0, 32'd7);
    applyStimulus(1'b1, 30'h3FFFFFFE, 32'h0, 32'hA5A5A5A5);

    // Reset during the wait states of a write discards it.
    @(posedge clk);
    #1;
    cs_a = 1'b0; as_a = 1'b0; rw_a = 1'b0; addr_a = 30'h1; wr_data_a = 32'hCAFEF00D;
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0; cs_a = 1'b1; as_a = 1'b1;
    repeat (3) @(posedge clk);
    applyStimulus(1'b1, 30'h1, 32'h0, 32'h0);

    // Zero-wait slave with the strobe held across two requests: no re-accept in the ready cycle.
    @(posedge clk);
    #1;
    cs_b = 1'b0; as_b = 1'b0; rw_b = 1'b0; addr_b = 30'h7; wr_data_b = 32'h0BADF00D;
    qb.push_back('{cyc: cyc + 1, data: 32'h0});
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (rdy_b === 1'b0) seen = 1;
    end
    if (!seen) checkOutput("B.rdy_timeout_1", 32'd1, 32'd0);
    rw_b = 1'b1;
    qb.push_back('{cyc: cyc + 2, data: 32'h0BADF00D});
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (rdy_b === 1'b0) seen = 1;
    end
    if (!seen) checkOutput("B.rdy_timeout_2", 32'd1, 32'd0);
    @(posedge clk);
    #1 cs_b = 1'b1; as_b = 1'b1;

    repeat (6) @(posedge clk);
    @(negedge clk);
    checkOutput("A.pending_responses", 32'(qa.size()), 32'd0);
    checkOutput("B.pending_responses", 32'(qb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/bus_reg_slave.md
# bus_reg_slave

Bus slave responder for the shared AZPR-style bus: it is the far end of the master-side address/strobe/read-write/write-data path. It decodes an access addressed to it, inserts a fixed number of wait states, and completes the access with a one-cycle active-low ready. Storage is a small word-addressed register file plus a read-only transaction counter. It is the template peripheral that other slaves on the bus follow.

## Interface
Parameters:
- `REG_ADDR_W`, default 4: register index width; the block holds 2^REG_ADDR_W words.
- `WAIT_CYCLES`, default 2: wait states inserted before ready; legal range 0..15.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `cs_` in 1: chip select from the address decoder; active low.
- `as_` in 1: address strobe; active low.
- `rw` in 1: `READ` (1) or `WRITE` (0).
- `addr` in 30: word address. Only `addr[REG_ADDR_W-1:0]` is decoded; upper bits alias.
- `wr_data` in 32: write data.
- `rd_data` out 32: read data, registered.
- `rdy_` out 1: ready; active low, registered.

## Operation
- The FSM has three states: IDLE, WAIT and RESP.
- **IDLE**
  - A request is `cs_==0 && as_==0`. When a request is sampled, latch the index, `rw` and `wr_data`.
  - If `WAIT_CYCLES==0`, go to RESP. Otherwise go to WAIT with the counter loaded to `WAIT_CYCLES-1`.
- **WAIT**
  - While the request holds: if the counter is 0, go to RESP; otherwise decrement.
  - If `cs_` or `as_` goes high, abort to IDLE. An abort performs no write, no count and no `rdy_`.
- **Entry into RESP**, on the edge leaving IDLE or WAIT:
  - Write: `regs[idx] <= wr_data`.
  - Read: `rd_data <= regs[idx]`.
  - The same edge drives `rdy_` low and increments `xact_cnt`.
- **RESP**
  - Lasts exactly one cycle with `rdy_=0`, then returns to IDLE unconditionally.
  - The request still visible in this cycle is not re-accepted.
- **Outputs outside RESP**: `rdy_=1` and `rd_data=0`, so the slave-side mux can OR or select safely.
  - Write transactions return `rd_data=0` in RESP.
- **Transaction counter**
  - The top index `2^REG_ADDR_W-1` is the read-only `xact_cnt` (32-bit). It counts completed transactions, both reads and writes, and wraps from 0xFFFF_FFFF to 0.
  - Writes to the top index are acknowledged but discarded.
  - A read of the top index returns the count before that read's own increment.
- **Reset**: `regs` all 0, `xact_cnt=0`, state IDLE, counter 0, `rdy_=1`, `rd_data=0`.
  - Reset asserted mid-transaction discards that transaction: no write, no `rdy_`.

## Timing
- Request sampled at the end of cycle T. `rdy_` is low in cycle T+1+WAIT_CYCLES only.
- Back-to-back requests: the earliest next acceptance is the first IDLE cycle, T+2+WAIT_CYCLES. Throughput is one access per WAIT_CYCLES+2 cycles.
- A write is visible to any later read, because it completes before RESP.
- The master must hold `addr`, `rw`, `wr_data`, `cs_` and `as_` until it sees `rdy_` low. Input changes in WAIT other than deassertion are ignored, because the values were latched in IDLE.
- Combinational paths from inputs to outputs: none.

## Test plan
- **Reset**
  - Stimulus: hold `reset` for 2 cycles, then read index 3.
  - Required: `rdy_=1` and `rd_data=0` during reset. The read returns 0 with `rdy_` low exactly 3 cycles after acceptance (WAIT_CYCLES=2).
- **Write/read**
  - Stimulus: write 0xDEADBEEF to addr 0x5, then read addr 0x15 (aliases index 5).
  - Required: the read returns 0xDEADBEEF. Each `rdy_` pulse is 1 cycle wide. `rd_data=0` outside RESP.
- **Abort**
  - Stimulus: start a write of 0x12345678 to index 2, then deassert `as_` in the first WAIT cycle.
  - Required: no `rdy_`. A subsequent read of index 2 returns 0 and of index 15 returns 1 (only the read of index 2 counted).
- **Counter**
  - Stimulus: perform 5 accesses, then read index 15, then write 0xFFFF to index 15 and read index 15 again.
  - Required: the reads return 5 and then 7; the write is ignored but counted.
- **Zero wait / back-to-back**
  - Stimulus: WAIT_CYCLES=0, with `as_` held low across two requests.
  - Required: `rdy_` low at T+1 and T+3, with no double-accept in the RESP cycle.
- **Mid-op reset**
  - Stimulus: assert `reset` during WAIT of a write to index 1.
  - Required: no `rdy_`, and index 1 reads 0 afterwards.
